// File: rtl/pcode_pkg.sv
// Shared types and decode helper for the 4-input priority encoder link.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package pcode_pkg;

    localparam int PCODE_W = 3;
    localparam int X_W     = 4;

    typedef logic [PCODE_W-1:0] pcode_t;
    typedef logic [X_W:1]       xvec_t;

    // Decoded payload carried through the output buffer.
    typedef struct packed {
        logic  illegal;
        xvec_t x;
    } dec_t;

    // Occupancy of the 2-entry output buffer.
    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } occ_t;

    // Priority code back to the one-hot request it stands for; 5..7 are not legal codes.
    function automatic dec_t pcode_to_onehot(input pcode_t p);
        dec_t d;
        d.illegal = 1'b0;
        d.x       = '0;
        case (p)
            3'd1:    d.x = 4'b0001;
            3'd2:    d.x = 4'b0010;
            3'd3:    d.x = 4'b0100;
            3'd4:    d.x = 4'b1000;
            3'd5,
            3'd6,
            3'd7:    d.illegal = 1'b1;
            default: d.x = '0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/skid_fifo2.sv
// Generic 2-entry valid/ready buffer; head entry drives the outputs.
// Latency: 1 cycle from accept to o_out_vld when empty; full rate with i_out_rdy high.
// Backpressure: o_in_rdy is registered from occupancy only, low while two entries are held.
module skid_fifo2
    import pcode_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_in_vld,
    output logic          o_in_rdy,
    input  logic [DW-1:0] i_in_dat,
    output logic          o_out_vld,
    input  logic          i_out_rdy,
    output logic [DW-1:0] o_out_dat
);

    occ_t          r_state;
    logic          r_in_rdy;
    logic          r_out_vld;
    logic [DW-1:0] r_head;
    logic [DW-1:0] r_tail;

    logic w_push;
    logic w_pop;

    assign w_push    = i_in_vld && r_in_rdy;
    assign w_pop     = r_out_vld && i_out_rdy;
    assign o_in_rdy  = r_in_rdy;
    assign o_out_vld = r_out_vld;
    assign o_out_dat = r_head;

    // Occupancy FSM; ready/valid flags are registered alongside the state so
    // in_ready never depends combinationally on the downstream ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_EMPTY;
            r_in_rdy  <= 1'b0;
            r_out_vld <= 1'b0;
            r_head    <= '0;
            r_tail    <= '0;
        end else begin
            r_in_rdy <= 1'b1;
            case (r_state)
                S_EMPTY: begin
                    if (w_push) begin
                        r_head    <= i_in_dat;
                        r_out_vld <= 1'b1;
                        r_state   <= S_ONE;
                    end
                end
                S_ONE: begin
                    if (w_push && !w_pop) begin
                        r_tail   <= i_in_dat;
                        r_in_rdy <= 1'b0;
                        r_state  <= S_TWO;
                    end else if (!w_push && w_pop) begin
                        r_out_vld <= 1'b0;
                        r_state   <= S_EMPTY;
                    end else if (w_push && w_pop) begin
                        // Head leaves while the new code arrives: it becomes head directly.
                        r_head <= i_in_dat;
                    end
                end
                S_TWO: begin
                    if (w_pop) begin
                        r_head  <= r_tail;
                        r_state <= S_ONE;
                    end else begin
                        r_in_rdy <= 1'b0;
                    end
                end
                default: begin
                    r_out_vld <= 1'b0;
                    r_state   <= S_EMPTY;
                end
            endcase
        end
    end

endmodule

// File: rtl/priority_decoder_pipe.sv
// Registered decoder from 3-bit priority code to one-hot x[4:1], with illegal-code tracking.
// Latency: 1 cycle from accept to out_valid when empty; 1 code/cycle with out_ready high.
// Backpressure: 2-entry buffer; in_ready drops (registered) once two results are held.
module priority_decoder_pipe
    import pcode_pkg::*;
#(
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [PCODE_W-1:0]   pcode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [X_W:1]         x,
    output logic                 illegal,
    output logic [ERR_CNT_W-1:0] err_cnt,
    output logic                 err_sticky
);

    dec_t                 w_dec;
    dec_t                 w_head;
    logic [X_W:0]         w_dec_bits;
    logic [X_W:0]         w_head_bits;
    logic                 w_accept;
    logic [ERR_CNT_W-1:0] r_err_cnt;
    logic                 r_err_sticky;

    assign w_dec       = pcode_to_onehot(pcode);
    assign w_dec_bits  = w_dec;
    assign w_head      = w_head_bits;
    assign w_accept    = in_valid && in_ready;

    assign x           = w_head.x;
    assign illegal     = w_head.illegal;
    assign err_cnt     = r_err_cnt;
    assign err_sticky  = r_err_sticky;

    skid_fifo2 #(
        .DW (X_W + 1)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .i_in_vld  (in_valid),
        .o_in_rdy  (in_ready),
        .i_in_dat  (w_dec_bits),
        .o_out_vld (out_valid),
        .i_out_rdy (out_ready),
        .o_out_dat (w_head_bits)
    );

    // Illegal codes are counted when accepted, not when they reach the output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err_cnt    <= '0;
            r_err_sticky <= 1'b0;
        end else if (w_accept && w_dec.illegal) begin
            r_err_sticky <= 1'b1;
            if (r_err_cnt != {ERR_CNT_W{1'b1}}) begin
                r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
            end
        end
    end

endmodule
